// File: rtl/reg_xfer_sequencer.sv
// Command sequencer for an 8-entry 1W/1R register file: MOV, LDI, SWAP (via temp reg) and CLRALL.
// Step outputs are decoded from the registered state/step; MOV-style writes pass read data straight through.
module reg_xfer_sequencer #(
  parameter int DATA_W   = 8,
  parameter int TEMP_REG = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [2:0]        cmd_src,
  input  logic [2:0]        cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              stall,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [2:0]        rf_sel_out,
  output logic              rf_oe,
  output logic [2:0]        rf_sel_in,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_e;

  localparam logic [1:0] OP_MOV  = 2'd0;
  localparam logic [1:0] OP_LDI  = 2'd1;
  localparam logic [1:0] OP_SWAP = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;
  localparam logic [2:0] TREG    = 3'(TEMP_REG);

  state_e            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [1:0]        op_q, op_d;
  logic [2:0]        src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              err_q, err_d;
  logic              illegal;
  logic [2:0]        last_step;

  assign illegal = (cmd_op == OP_SWAP) && ((cmd_src == TREG) || (cmd_dst == TREG));

  always_comb begin
    case (op_q)
      OP_SWAP: last_step = 3'd2;
      OP_CLR:  last_step = 3'd7;
      default: last_step = 3'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        src_d   = cmd_src;
        dst_d   = cmd_dst;
        imm_d   = cmd_imm;
        step_d  = 3'd0;
        err_d   = illegal;
        state_d = illegal ? S_DONE : S_STEP;
      end
      S_STEP: if (!stall) begin
        if (step_q == last_step) state_d = S_DONE;
        else                     step_d  = step_q + 3'd1;
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      err_q   <= err_d;
    end
  end

  // Strobes are gated by reset so an aborting edge never commits a write.
  logic wr_act, rd_act;
  always_comb begin
    wr_act     = 1'b0;
    rd_act     = 1'b0;
    rf_sel_out = '0;
    rf_sel_in  = '0;
    rf_wr_data = '0;
    if (state_q == S_STEP) begin
      wr_act = 1'b1;
      case (op_q)
        OP_MOV: begin
          rd_act = 1'b1; rf_sel_out = src_q; rf_sel_in = dst_q; rf_wr_data = rf_rd_data;
        end
        OP_LDI: begin
          rf_sel_in = dst_q; rf_wr_data = imm_q;
        end
        OP_SWAP: begin
          rd_act     = 1'b1;
          rf_wr_data = rf_rd_data;
          case (step_q)
            3'd0:    begin rf_sel_out = src_q; rf_sel_in = TREG;  end
            3'd1:    begin rf_sel_out = dst_q; rf_sel_in = src_q; end
            default: begin rf_sel_out = TREG;  rf_sel_in = dst_q; end
          endcase
        end
        default: rf_sel_in = step_q;
      endcase
    end
  end

  assign rf_we     = wr_act && !stall && !reset;
  assign rf_oe     = rd_act && !stall && !reset;
  assign cmd_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = done && err_q;
endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Directed bench for reg_xfer_sequencer with a behavioural 8x8 register file attached.
module tb_reg_xfer_sequencer;
  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_ready, stall;
  logic [1:0] cmd_op;
  logic [2:0] cmd_src, cmd_dst;
  logic [7:0] cmd_imm, rf_rd_data, rf_wr_data;
  logic [2:0] rf_sel_out, rf_sel_in;
  logic       rf_oe, rf_we, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;
  int done_cnt = 0;
  logic [7:0] rf_m [8] = '{default: 8'h00};

  reg_xfer_sequencer #(.DATA_W(8), .TEMP_REG(7)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .stall(stall), .rf_rd_data(rf_rd_data), .rf_sel_out(rf_sel_out), .rf_oe(rf_oe),
    .rf_sel_in(rf_sel_in), .rf_we(rf_we), .rf_wr_data(rf_wr_data),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign rf_rd_data = rf_m[rf_sel_out];
  always @(posedge clk) begin
    if (rf_we) begin
      rf_m[rf_sel_in] <= rf_wr_data;
      we_cnt <= we_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents a command for one edge; returns 1ns into the first cycle after acceptance.
  task automatic issue(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                       input logic [7:0] imm);
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_src = 3'd0; cmd_dst = 3'd0; cmd_imm = 8'h00;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 40) begin tick(); t++; end
    chk(tag, done, 1'b1);
  endtask

  task automatic run(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                     input logic [7:0] imm);
    issue(op, src, dst, imm);
    wait_done("run_done");
    tick();
  endtask

  int w0, d0;
  logic [7:0] r3_snap, r7_snap;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; stall = 1'b0;
    cmd_op = 2'd0; cmd_src = 3'd0; cmd_dst = 3'd0; cmd_imm = 8'h00;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_we",    rf_we, 1'b0);
    chk("rst_oe",    rf_oe, 1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_err",   err, 1'b0);
    chk("rst_wdata", rf_wr_data, 8'h00);
    chk("rst_selin", rf_sel_in, 3'd0);

    // LDI R2 <- 5A
    w0 = we_cnt;
    issue(2'd1, 3'd0, 3'd2, 8'h5A);
    chk("ldi_ready", cmd_ready, 1'b0);
    chk("ldi_we",    rf_we, 1'b1);
    chk("ldi_oe",    rf_oe, 1'b0);
    chk("ldi_selin", rf_sel_in, 3'd2);
    chk("ldi_wdata", rf_wr_data, 8'h5A);
    chk("ldi_done0", done, 1'b0);
    tick();
    chk("ldi_done",  done, 1'b1);
    chk("ldi_err",   err, 1'b0);
    chk("ldi_rdy1",  cmd_ready, 1'b0);
    chk("ldi_we1",   rf_we, 1'b0);
    tick();
    chk("ldi_rdy2",  cmd_ready, 1'b1);
    chk("ldi_done2", done, 1'b0);
    chk("ldi_r2",    rf_m[2], 8'h5A);
    chk("ldi_wecnt", we_cnt - w0, 1);

    // MOV R4 <- R2
    w0 = we_cnt;
    issue(2'd0, 3'd2, 3'd4, 8'h00);
    chk("mov_oe",     rf_oe, 1'b1);
    chk("mov_selout", rf_sel_out, 3'd2);
    chk("mov_selin",  rf_sel_in, 3'd4);
    chk("mov_wdata",  rf_wr_data, 8'h5A);
    chk("mov_ready",  cmd_ready, 1'b0);
    tick();
    chk("mov_done",   done, 1'b1);
    chk("mov_rdy1",   cmd_ready, 1'b0);
    tick();
    chk("mov_rdy2",   cmd_ready, 1'b1);
    chk("mov_r4",     rf_m[4], 8'h5A);
    chk("mov_wecnt",  we_cnt - w0, 1);

    // SWAP R0 <-> R1 through R7
    run(2'd1, 3'd0, 3'd0, 8'h11);
    run(2'd1, 3'd0, 3'd1, 8'h22);
    w0 = we_cnt;
    issue(2'd2, 3'd0, 3'd1, 8'h00);
    chk("sw0_selin",  rf_sel_in, 3'd7);
    chk("sw0_selout", rf_sel_out, 3'd0);
    chk("sw0_wdata",  rf_wr_data, 8'h11);
    chk("sw0_we",     rf_we, 1'b1);
    tick();
    chk("sw1_r7",     rf_m[7], 8'h11);
    chk("sw1_selin",  rf_sel_in, 3'd0);
    chk("sw1_selout", rf_sel_out, 3'd1);
    chk("sw1_wdata",  rf_wr_data, 8'h22);
    tick();
    chk("sw2_r0",     rf_m[0], 8'h22);
    chk("sw2_selin",  rf_sel_in, 3'd1);
    chk("sw2_selout", rf_sel_out, 3'd7);
    chk("sw2_wdata",  rf_wr_data, 8'h11);
    tick();
    chk("sw_done",    done, 1'b1);
    chk("sw_err",     err, 1'b0);
    chk("sw_r1",      rf_m[1], 8'h11);
    chk("sw_wecnt",   we_cnt - w0, 3);
    tick();
    chk("sw_ready",   cmd_ready, 1'b1);

    // Illegal SWAP touching the temp register
    w0 = we_cnt; r3_snap = rf_m[3]; r7_snap = rf_m[7];
    issue(2'd2, 3'd7, 3'd3, 8'h00);
    chk("ill_done", done, 1'b1);
    chk("ill_err",  err, 1'b1);
    chk("ill_we",   rf_we, 1'b0);
    tick();
    chk("ill_ready", cmd_ready, 1'b1);
    chk("ill_err0",  err, 1'b0);
    chk("ill_wecnt", we_cnt - w0, 0);
    chk("ill_r3",    rf_m[3], r3_snap);
    chk("ill_r7",    rf_m[7], r7_snap);

    // SWAP with src==dst: three writes, value unchanged
    w0 = we_cnt;
    run(2'd2, 3'd2, 3'd2, 8'h00);
    chk("self_wecnt", we_cnt - w0, 3);
    chk("self_r2",    rf_m[2], 8'h5A);

    // CLRALL after filling with FF
    for (int r = 0; r < 8; r++) run(2'd1, 3'd0, 3'(r), 8'hFF);
    chk("fill_r5", rf_m[5], 8'hFF);
    issue(2'd3, 3'd0, 3'd0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      chk("clr_selin", rf_sel_in, k);
      chk("clr_we",    rf_we, 1'b1);
      chk("clr_wdata", rf_wr_data, 8'h00);
      tick();
    end
    chk("clr_done", done, 1'b1);
    chk("clr_err",  err, 1'b0);
    for (int r = 0; r < 8; r++) chk("clr_reg", rf_m[r], 8'h00);
    tick();

    // MOV stalled for 3 cycles in STEP
    run(2'd1, 3'd0, 3'd3, 8'h3C);
    w0 = we_cnt;
    issue(2'd0, 3'd3, 3'd5, 8'h00);
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stl_we",   rf_we, 1'b0);
      chk("stl_oe",   rf_oe, 1'b0);
      chk("stl_done", done, 1'b0);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("stl_wecnt0", we_cnt - w0, 0);
    chk("stl_we1",    rf_we, 1'b1);
    chk("stl_selin",  rf_sel_in, 3'd5);
    chk("stl_wdata",  rf_wr_data, 8'h3C);
    tick();
    chk("stl_done1",  done, 1'b1);
    chk("stl_r5",     rf_m[5], 8'h3C);
    chk("stl_wecnt",  we_cnt - w0, 1);
    tick();

    // Reset during SWAP step 1
    run(2'd1, 3'd0, 3'd0, 8'hA1);
    run(2'd1, 3'd0, 3'd1, 8'hB2);
    d0 = done_cnt;
    issue(2'd2, 3'd0, 3'd1, 8'h00);
    tick();
    chk("rab_selin", rf_sel_in, 3'd0);
    reset = 1'b1;
    #1;
    chk("rab_we",    rf_we, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("rab_ready", cmd_ready, 1'b1);
    chk("rab_we1",   rf_we, 1'b0);
    chk("rab_done",  done, 1'b0);
    tick(); tick();
    chk("rab_dcnt",  done_cnt - d0, 0);
    chk("rab_r7",    rf_m[7], 8'hA1);
    chk("rab_r0",    rf_m[0], 8'hA1);
    chk("rab_r1",    rf_m[1], 8'hB2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
